// File: rtl/mem_map_pkg.sv
// Shared address map and loader state encoding for the CPU-side memory responder.
package mem_map_pkg;

  localparam int         DEPTH        = 256;
  localparam logic [7:0] MMIO_BASE    = 8'hFC;
  localparam logic [7:0] LD_LAST      = MMIO_BASE - 8'd1;
  localparam logic [7:0] ADDR_SW_LEDH = 8'hFC;
  localparam logic [7:0] ADDR_LEDL    = 8'hFD;
  localparam logic [7:0] ADDR_RDCNT   = 8'hFE;
  localparam logic [7:0] ADDR_WRCNT   = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/mem_loader_fsm.sv
// Program loader: RUN -> LOAD -> DONE -> RUN. Holds the CPU while filling RAM from address 0.
// Loader handshake: a byte transfers on a rising edge where i_ld_valid and o_ld_ready are both high.
module mem_loader_fsm
  import mem_map_pkg::*;
(
  input  logic      i_clock,
  input  logic      i_reset,
  input  logic      i_ld_start,
  input  logic      i_ld_valid,
  output logic      o_ld_ready,
  output logic      o_cpu_hold,
  output logic      o_we,
  output logic [7:0] o_waddr,
  output ld_state_t o_state
);

  ld_state_t  r_state;
  ld_state_t  w_next;
  logic [7:0] r_ptr;
  logic [7:0] w_ptr_next;
  logic       w_accept;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_ptr   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ptr_next = r_ptr;
    w_accept   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_ld_start) begin
          w_next     = ST_LOAD;
          w_ptr_next = 8'd0;
        end
      end
      ST_LOAD: begin
        // A byte arriving with ld_start is still written before leaving LOAD.
        w_accept = i_ld_valid && (r_ptr < MMIO_BASE);
        if (w_accept) w_ptr_next = r_ptr + 8'd1;
        if (i_ld_start || (w_accept && (r_ptr == LD_LAST))) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_RUN;
      default: w_next = ST_RUN;
    endcase
  end

  assign o_ld_ready = (r_state == ST_LOAD);
  assign o_cpu_hold = (r_state != ST_RUN);
  assign o_we       = w_accept;
  assign o_waddr    = r_ptr;
  assign o_state    = r_state;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: 256x8 RAM, LED/switch MMIO at FC..FF, registered read data, program loader.
// Optional build macro ACCESS_COUNT_EN adds saturating CPU read/write counters readable at FE/FF.
module mem_bus_responder
  import mem_map_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       wren,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  input  logic [3:0] sw_in,
  output logic [9:0] led_out,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       cpu_hold,
  output logic [1:0] dbg_state
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;
  logic [9:0] r_led;
  logic [7:0] w_rd_data;
  logic       w_ld_we;
  logic [7:0] w_ld_addr;
  ld_state_t  w_state;
  logic       w_run;

  mem_loader_fsm u_loader (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_ld_start (ld_start),
    .i_ld_valid (ld_valid),
    .o_ld_ready (ld_ready),
    .o_cpu_hold (cpu_hold),
    .o_we       (w_ld_we),
    .o_waddr    (w_ld_addr),
    .o_state    (w_state)
  );

  assign w_run = (w_state == ST_RUN);

`ifdef ACCESS_COUNT_EN
  logic [7:0] r_rd_cnt;
  logic [7:0] r_wr_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= 8'd0;
      r_wr_cnt <= 8'd0;
    end else if (w_run && ld_start) begin
      r_rd_cnt <= 8'd0;
      r_wr_cnt <= 8'd0;
    end else if (w_run) begin
      if (MemRead && (r_rd_cnt != 8'hFF)) r_rd_cnt <= r_rd_cnt + 8'd1;
      if (wren && (r_wr_cnt != 8'hFF)) r_wr_cnt <= r_wr_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    w_rd_data = 8'd0;
    if (address < MMIO_BASE) begin
      w_rd_data = r_mem[address];
    end else begin
      case (address)
        ADDR_SW_LEDH: w_rd_data = {4'b0000, sw_in};
        ADDR_LEDL:    w_rd_data = r_led[7:0];
`ifdef ACCESS_COUNT_EN
        ADDR_RDCNT:   w_rd_data = r_rd_cnt;
        ADDR_WRCNT:   w_rd_data = r_wr_cnt;
`endif
        default:      w_rd_data = 8'd0;
      endcase
    end
  end

  // RAM is never cleared so a loaded program survives a reset.
  always_ff @(posedge clock) begin
    if (w_ld_we) r_mem[w_ld_addr] <= ld_data;
    else if (w_run && wren && (address < MMIO_BASE)) r_mem[address] <= data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q   <= 8'd0;
      r_led <= 10'd0;
    end else if (w_run) begin
      if (MemRead) r_q <= w_rd_data;
      if (wren) begin
        if (address == ADDR_SW_LEDH) r_led[9:8] <= data[1:0];
        else if (address == ADDR_LEDL) r_led[7:0] <= data;
      end
    end
  end

  assign q         = r_q;
  assign led_out   = r_led;
  assign dbg_state = w_state;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: CPU bus, MMIO, loader FSM, reset mid-load, optional counters.
module tb_mem_bus_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       MemRead, wren;
  logic [7:0] address, data, q;
  logic [3:0] sw_in;
  logic [9:0] led_out;
  logic       ld_start, ld_valid, ld_ready, cpu_hold;
  logic [7:0] ld_data;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_bus_responder dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .wren      (wren),
    .address   (address),
    .data      (data),
    .q         (q),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .cpu_hold  (cpu_hold),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    address = a; data = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    address = a; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
  endtask

  task automatic ld_byte(input logic [7:0] d);
    ld_data = d; ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic start_pulse();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; wren = 1'b0; address = 8'd0; data = 8'd0;
    sw_in = 4'd0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'd0;
    @(negedge clock); @(negedge clock);
    chk("rst_q", q, 8'h00);
    chk("rst_led", led_out, 10'h000);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_ready", ld_ready, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    tick();

    // Basic write then read
    cpu_wr(8'd10, 8'h5A);
    cpu_rd(8'd10);
    chk("rd_10", q, 8'h5A);

    // Same-edge read and write returns the old byte
    cpu_wr(8'd20, 8'h11);
    address = 8'd20; data = 8'h22; MemRead = 1'b1; wren = 1'b1;
    tick();
    MemRead = 1'b0; wren = 1'b0;
    chk("rbw_old", q, 8'h11);
    cpu_rd(8'd20);
    chk("rbw_new", q, 8'h22);
    tick();
    chk("q_hold", q, 8'h22);

    // MMIO
    sw_in = 4'hB;
    cpu_rd(8'hFC);
    chk("sw_rd", q, 8'h0B);
    cpu_wr(8'hFD, 8'hC3);
    cpu_wr(8'hFC, 8'h02);
    chk("led_wr", led_out, 10'h2C3);
    cpu_rd(8'hFD);
    chk("ledl_rd", q, 8'hC3);
`ifndef ACCESS_COUNT_EN
    cpu_rd(8'hFE);
    chk("fe_zero", q, 8'h00);
    cpu_rd(8'hFF);
    chk("ff_zero", q, 8'h00);
`endif

    // Loader with gaps; CPU traffic ignored during LOAD
    cpu_rd(8'd10);
    chk("pre_ld_q", q, 8'h5A);
    start_pulse();
    chk("ld_state", dbg_state, 2'd1);
    chk("ld_hold", cpu_hold, 1'b1);
    chk("ld_ready", ld_ready, 1'b1);
    ld_byte(8'h00);
    tick();
    ld_byte(8'h01);
    cpu_wr(8'd1, 8'hEE);
    address = 8'd20; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
    chk("ld_q_hold", q, 8'h5A);
    ld_byte(8'h02);
    chk("ld_still", dbg_state, 2'd1);
    ld_start = 1'b1;
    tick();
    chk("done_state", dbg_state, 2'd2);
    chk("done_hold", cpu_hold, 1'b1);
    chk("done_ready", ld_ready, 1'b0);
    tick();
    ld_start = 1'b0;
    chk("exit_state", dbg_state, 2'd0);
    chk("exit_hold", cpu_hold, 1'b0);
    cpu_rd(8'd0); chk("ld_mem0", q, 8'h00);
    cpu_rd(8'd1); chk("ld_mem1", q, 8'h01);
    cpu_rd(8'd2); chk("ld_mem2", q, 8'h02);

    // Reset in the middle of a load
    start_pulse();
    ld_byte(8'hAA);
    ld_byte(8'hBB);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_hold", cpu_hold, 1'b0);
    chk("mid_rst_state", dbg_state, 2'd0);
    chk("mid_rst_ready", ld_ready, 1'b0);
    chk("mid_rst_q", q, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    cpu_rd(8'd0); chk("keep_mem0", q, 8'hAA);
    cpu_rd(8'd1); chk("keep_mem1", q, 8'hBB);
    cpu_rd(8'd2); chk("keep_mem2", q, 8'h02);

    // Full fill ends on its own at the last byte below MMIO
    cpu_wr(8'hFD, 8'hC3);
    cpu_wr(8'hFC, 8'h02);
    start_pulse();
    for (int i = 0; i < 252; i++) ld_byte(8'(i) ^ 8'h3C);
    chk("fill_done", dbg_state, 2'd2);
    chk("fill_ready", ld_ready, 1'b0);
    tick();
    chk("fill_run", dbg_state, 2'd0);
    cpu_rd(8'hFB); chk("fill_last", q, 8'hC7);
    cpu_rd(8'h00); chk("fill_first", q, 8'h3C);
    chk("fill_led", led_out, 10'h2C3);

`ifdef ACCESS_COUNT_EN
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    cpu_rd(8'd0); cpu_rd(8'd1); cpu_rd(8'd2);
    cpu_wr(8'd30, 8'h01); cpu_wr(8'd31, 8'h02);
    cpu_rd(8'hFE); chk("rd_cnt", q, 8'h03);
    cpu_rd(8'hFF); chk("wr_cnt", q, 8'h02);
    for (int i = 0; i < 300; i++) cpu_rd(8'd0);
    cpu_rd(8'hFE); chk("rd_sat", q, 8'hFF);
    start_pulse();
    start_pulse();
    tick();
    cpu_rd(8'hFE); chk("rd_clr_load", q, 8'h00);
    cpu_rd(8'hFF); chk("wr_clr_load", q, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
